// File: rtl/vpe_sched_drv.sv
// VPE scheduling driver: masked round-robin pointer, shuffle-mapped VUL enables, round tracking.
// Optional stall counter output enabled by defining VPE_SCHED_PERF_EN.
module vpe_sched_drv #(
   parameter int unsigned NUM_VPE = 12,
   parameter int unsigned RND_W   = 16,
   parameter int unsigned IDX_W   = $clog2(NUM_VPE)
) (
   input  logic               wCLKB,
   input  logic               wRESET_ND,
   input  logic               SRAM_STATE,
   input  logic               VAR_STATE,
   input  logic               PROC_STATE,
   input  logic               STALL,
   input  logic               ROUND_CLR,
   input  logic [1:0]         SHF_MODE,
   input  logic [NUM_VPE-1:0] VPE_MASK,
   output logic [NUM_VPE-1:0] VUL_EN,
   output logic               SATISFY_EN,
   output logic               ROUND_DONE,
   output logic [RND_W-1:0]   ROUND_CNT,
`ifdef VPE_SCHED_PERF_EN
   output logic [RND_W-1:0]   STALL_CNT,
`endif
   output logic [IDX_W-1:0]   CUR_IDX
);

   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [RND_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [IDX_W-1:0]   hi_c, lo_c, nxt_c;
   logic               nxt_found_c;
   logic               any_c;
   logic [NUM_VPE-1:0] cur_c, shf_c;

   // Lowest/highest active VPE and the first active VPE strictly above the pointer
   always_comb begin : mask_scan
      hi_c        = '0;
      lo_c        = '0;
      nxt_c       = '0;
      nxt_found_c = 1'b0;
      for (int i = NUM_VPE - 1; i >= 0; i--) begin
         if (VPE_MASK[i]) begin
            lo_c = IDX_W'(i);
            if (IDX_W'(i) > idx_q) begin
               nxt_c       = IDX_W'(i);
               nxt_found_c = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_VPE; i++) begin
         if (VPE_MASK[i]) hi_c = IDX_W'(i);
      end
   end

   assign any_c = |VPE_MASK;

   // Pointer advance; wrapping to lo closes a round
   always_comb begin : next_state
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (ROUND_CLR) begin
         idx_d = '0;
         cnt_d = '0;
      end else if (PROC_STATE && !STALL && any_c) begin
         if (nxt_found_c) begin
            idx_d = nxt_c;
         end else begin
            idx_d  = lo_c;
            done_d = 1'b1;
            cnt_d  = cnt_q + RND_W'(1);
         end
      end
   end

   always_ff @(posedge wCLKB or negedge wRESET_ND) begin
      if (!wRESET_ND) begin
         idx_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

`ifdef VPE_SCHED_PERF_EN
   logic [RND_W-1:0] stall_q, stall_d;

   always_comb begin : stall_next
      stall_d = stall_q;
      if (ROUND_CLR)                stall_d = '0;
      else if (PROC_STATE && STALL) stall_d = stall_q + RND_W'(1);
   end

   always_ff @(posedge wCLKB or negedge wRESET_ND) begin
      if (!wRESET_ND) stall_q <= '0;
      else            stall_q <= stall_d;
   end

   assign STALL_CNT = stall_q;
`endif

   assign cur_c = VPE_MASK & (NUM_VPE'(1) << idx_q);

   // Shuffle order applied to the one-hot pointer
   always_comb begin : shuffle
      shf_c = cur_c;
      case (SHF_MODE)
         2'd1: begin
            shf_c = '0;
            for (int k = 0; k < NUM_VPE / 2; k++) begin
               shf_c[2*k]   = cur_c[k];
               shf_c[2*k+1] = cur_c[NUM_VPE-1-k];
            end
            if ((NUM_VPE % 2) == 1) shf_c[NUM_VPE-1] = cur_c[(NUM_VPE-1)/2];
         end
         2'd2: begin
            for (int i = 0; i < NUM_VPE; i++) shf_c[i] = cur_c[NUM_VPE-1-i];
         end
         default: shf_c = cur_c;
      endcase
   end

   assign VUL_EN     = SRAM_STATE ? '0 : (VAR_STATE ? '1 : shf_c);
   assign SATISFY_EN = any_c && (idx_q == hi_c) && VPE_MASK[idx_q];
   assign ROUND_DONE = done_q;
   assign ROUND_CNT  = cnt_q;
   assign CUR_IDX    = idx_q;

endmodule

// File: doc/vpe_sched_drv.md
Name: vpe_sched_drv

Overview:
Parametrised VPE scheduling driver for the SAT array, generalising the 12-VPE clock/enable driver. It rotates a single active-VPE pointer over NUM_VPE processing elements and skips VPEs disabled by a runtime mask. It maps the pointer through one of several selectable shuffle orders and drives per-VPE VUL enables. It also reports round completion, maintains a round counter, and asserts SATISFY_EN on the last active VPE of each round.

Parameters:
NUM_VPE, 12, number of VPEs driven; legal range 2..64.
RND_W, 16, width of the round counter.
IDX_W, $clog2(NUM_VPE), width of the pointer index (derived; do not override).

Ports:
wCLKB  in  1  clock; all flops update on its rising edge.
wRESET_ND  in  1  asynchronous, active-low reset.
SRAM_STATE  in  1  SRAM load phase; forces VUL_EN to all-zero.
VAR_STATE  in  1  variable phase; forces VUL_EN to all-one (SRAM_STATE has priority).
PROC_STATE  in  1  processing phase; enables pointer advance.
STALL  in  1  freezes the pointer and round logic while high.
ROUND_CLR  in  1  synchronous clear of the pointer and the round counter.
SHF_MODE  in  2  0 identity, 1 fold-interleave, 2 reverse, 3 identity (reserved).
VPE_MASK  in  NUM_VPE  1 = VPE participates in rotation.
VUL_EN  out  NUM_VPE  per-VPE unit enable.
SATISFY_EN  out  1  high while the pointer is at the highest active VPE.
ROUND_DONE  out  1  one-cycle registered pulse at round wrap.
ROUND_CNT  out  RND_W  completed rounds, modulo 2^RND_W.
CUR_IDX  out  IDX_W  current pointer index.

Behaviour:
- Reset (wRESET_ND=0, asynchronous): idx=0, ROUND_CNT=0, ROUND_DONE=0. While reset is asserted, VUL_EN follows the combinational rules below using idx=0.
- Define hi = index of the highest set bit of VPE_MASK and lo = index of the lowest set bit. When VPE_MASK=0, there are no active VPEs.
- Sequential update priority on each wCLKB rising edge:
  1. ROUND_CLR: idx<=0, ROUND_CNT<=0, ROUND_DONE<=0.
  2. Else, if PROC_STATE & ~STALL & (VPE_MASK!=0): idx<=next set mask bit strictly above idx, cyclically.
     - If idx==hi, or no set bit lies above idx: idx<=lo, ROUND_DONE<=1, ROUND_CNT<=ROUND_CNT+1 (wraps).
  3. Else: idx holds and ROUND_DONE<=0.
- ROUND_DONE is 0 in every cycle that does not wrap. Back-to-back wraps are legal, for example when only one VPE is active: ROUND_DONE stays high and ROUND_CNT increments every cycle.
- Mask change mid-round: the next advance uses the current mask. If idx is now masked, the advance goes to the next active index above it, or wraps to lo with a ROUND_DONE pulse.
- Pointer one-hot: cur = (1<<idx) & VPE_MASK. A masked idx gives cur=0.
- Shuffle mapping, out = shf(cur):
  - Identity: out[i]=cur[i].
  - Fold-interleave: out[2k]=cur[k] and out[2k+1]=cur[NUM_VPE-1-k] for k<floor(NUM_VPE/2); if NUM_VPE is odd, out[NUM_VPE-1]=cur[(NUM_VPE-1)/2]. For NUM_VPE=12 this matches the legacy order {6,5,7,4,8,3,9,2,10,1,11,0} (MSB first).
  - Reverse: out[i]=cur[NUM_VPE-1-i].
- VUL_EN, combinational: SRAM_STATE ? 0 : VAR_STATE ? all-ones : shf(cur). VAR_STATE all-ones ignores VPE_MASK.
- SATISFY_EN, combinational: (VPE_MASK!=0) & (idx==hi) & VPE_MASK[idx]. It is independent of SHF_MODE and STALL.
- CUR_IDX = idx, registered.
- SHF_MODE may change on any cycle and affects VUL_EN combinationally only. No state depends on it.

Optional Feature:
VPE_SCHED_PERF_EN:
- Defined: adds output STALL_CNT [RND_W-1:0]. It increments (wrapping) on every edge where PROC_STATE & STALL; it resets to 0 on wRESET_ND and on ROUND_CLR.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. NUM_VPE=12, mask=FFF, SHF_MODE=0, PROC_STATE=1 for 12 edges -> VUL_EN steps 001,002,...,800 then 001. SATISFY_EN is high when VUL_EN=800. ROUND_DONE pulses once on the wrap edge. ROUND_CNT=1.
2. SHF_MODE=1, idx=1 -> VUL_EN=004. idx=11 -> VUL_EN=002. SHF_MODE=2, idx=0 -> VUL_EN=800.
3. mask=0x0A4 (VPEs 2,5,7), reset then PROC_STATE -> idx sequence 0,2,5,7,2. VUL_EN=000 while idx=0. SATISFY_EN is high at idx 7. ROUND_DONE pulses on the 7->2 edge.
4. Priority: SRAM_STATE=1 & VAR_STATE=1 -> VUL_EN=000. VAR_STATE=1 alone with mask=0 -> VUL_EN=FFF. STALL=1 for 5 cycles -> idx and ROUND_CNT are unchanged; STALL_CNT=5 when VPE_SCHED_PERF_EN is defined.
5. Mid-round: at idx=4, ROUND_CLR=1 and PROC_STATE=1 -> next idx=0, ROUND_CNT=0, no ROUND_DONE. Asynchronous reset pulse at idx=9 -> idx=0 immediately, without waiting for a clock edge.
6. mask=0x001, PROC_STATE=1 for 4 edges -> idx stays 0, ROUND_DONE is high on all 4 edges, ROUND_CNT=4.
